boot_ctrl: RTL and testbench

BOOT_CTRL -- requirements
Module: boot_ctrl

---
 rtl/boot_ctrl.sv | 106 ++++++++++
 tb/tb_boot_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_ctrl.sv
// Boot controller: loads a program into instruction memory, pulses core reset,
// runs the core under a watchdog, and parks it in HALT until the next load.
module boot_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int RST_CYCLES = 2,
    parameter int RUN_LIMIT  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_load,
    input  logic [ADDR_W-1:0] load_len,
    input  logic [31:0]       dataIN,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              halt_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              core_en,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       run_cycles
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CRST, S_RUN, S_HALT} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] len, wcnt;
    logic [RW-1:0]     rcnt;
    logic              go_load, accept, wdog;

    assign go_load    = start_load && (load_len != '0);
    assign accept     = (state == S_LOAD) && data_valid;
    assign wdog       = (run_cycles + 32'd1) == 32'(RUN_LIMIT);
    assign imem_we    = accept;
    assign imem_addr  = wcnt;
    assign imem_wdata = dataIN;

    always_comb begin
        state_nx   = state;
        data_ready = 1'b0;
        core_rst   = 1'b1;
        core_en    = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: if (go_load) state_nx = S_LOAD;
            S_LOAD: begin
                data_ready = 1'b1;
                if (accept && (wcnt == len - 1'b1)) state_nx = S_CRST;
            end
            S_CRST: if (rcnt == RW'(RST_CYCLES - 1)) state_nx = S_RUN;
            S_RUN: begin
                core_rst = 1'b0;
                core_en  = 1'b1;
                if (halt_req || wdog) state_nx = S_HALT;
            end
            S_HALT: begin
                // core reset stays low so its state can be inspected after halting
                core_rst = 1'b0;
                done     = 1'b1;
                if (go_load) state_nx = S_LOAD;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            len        <= '0;
            wcnt       <= '0;
            rcnt       <= '0;
            run_cycles <= '0;
            timeout    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE, S_HALT: begin
                    if (go_load) begin
                        len     <= load_len;
                        wcnt    <= '0;
                        timeout <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) wcnt <= wcnt + 1'b1;
                    if (state_nx == S_CRST) begin
                        rcnt       <= '0;
                        run_cycles <= '0;
                    end
                end
                S_CRST: rcnt <= rcnt + 1'b1;
                S_RUN: begin
                    run_cycles <= run_cycles + 32'd1;
                    // an explicit halt in the watchdog cycle is not a timeout
                    if (state_nx == S_HALT) timeout <= !halt_req;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl: load, reset pulse, halt, watchdog, reset mid-load.
module tb_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst, start_load, data_valid, halt_req;
    logic [3:0]  load_len;
    logic [31:0] dataIN;
    logic        data_ready, imem_we, core_rst, core_en, done, timeout;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata, run_cycles;

    int vecs = 0;
    int errs = 0;
    int nwr  = 0;

    boot_ctrl #(.ADDR_W(4), .RST_CYCLES(2), .RUN_LIMIT(20)) dut (
        .clk(clk), .rst(rst), .start_load(start_load), .load_len(load_len),
        .dataIN(dataIN), .data_valid(data_valid), .data_ready(data_ready),
        .halt_req(halt_req), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .core_en(core_en),
        .done(done), .timeout(timeout), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_we === 1'b1) nwr++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one word in LOAD and check the write it produces.
    task automatic feed_word(input logic [31:0] w, input logic [3:0] a);
        data_valid = 1'b1;
        dataIN     = w;
        #1;
        vecs++;
        if ({data_ready, imem_we, imem_addr, imem_wdata} !== {2'b11, a, w}) begin
            errs++;
            $display("FAIL write@%0d: got rdy/we/addr/data %b%b %h %h want 11 %h %h",
                     a, data_ready, imem_we, imem_addr, imem_wdata, a, w);
        end
        cyc();
        data_valid = 1'b0;
    endtask

    // Load a single word from HALT and advance to the first RUN cycle.
    task automatic reload_one(input logic [31:0] held);
        start_load = 1'b1;
        load_len   = 4'd1;
        cyc();
        start_load = 1'b0;
        #1;
        vecs++;
        if ({done, timeout, core_en, run_cycles} !== {3'b000, held}) begin
            errs++;
            $display("FAIL reload_load: got done/to/en %b%b%b run %0d want 000 run %0d",
                     done, timeout, core_en, run_cycles, held);
        end
        feed_word(32'h0000_0073, 4'd0);
        #1;
        vecs++;
        if ({core_rst, core_en, run_cycles} !== {2'b10, 32'd0}) begin
            errs++;
            $display("FAIL reload_crst: got rst/en %b%b run %0d want 10 run 0",
                     core_rst, core_en, run_cycles);
        end
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; start_load = 1'b0; load_len = '0; dataIN = '0;
        data_valid = 1'b0; halt_req = 1'b0;
        cyc();
        cyc();
        vecs++;
        if ({core_rst, core_en, data_ready, imem_we, done, timeout} !== 6'b100000) begin
            errs++;
            $display("FAIL reset_ctl: got %b%b%b%b%b%b want 100000",
                     core_rst, core_en, data_ready, imem_we, done, timeout);
        end
        vecs++;
        if ({run_cycles, imem_addr} !== 36'd0) begin
            errs++;
            $display("FAIL reset_cnt: got run %0d addr %0d want 0 0", run_cycles, imem_addr);
        end
    endtask

    task automatic test_load();
        int w0;
        w0 = nwr;
        rst        = 1'b0;
        start_load = 1'b1;
        load_len   = 4'd3;
        #1;
        vecs++;
        if (data_ready !== 1'b0) begin
            errs++;
            $display("FAIL idle_ready: got %b want 0", data_ready);
        end
        cyc();
        start_load = 1'b0;
        feed_word(32'h0050_0093, 4'd0);
        #1;
        vecs++;
        if ({imem_we, imem_addr} !== {1'b0, 4'd1}) begin
            errs++;
            $display("FAIL gap1: got we %b addr %0d want 0 1", imem_we, imem_addr);
        end
        cyc();
        feed_word(32'h00a0_0113, 4'd1);
        #1;
        vecs++;
        if ({imem_we, imem_addr} !== {1'b0, 4'd2}) begin
            errs++;
            $display("FAIL gap2: got we %b addr %0d want 0 2", imem_we, imem_addr);
        end
        cyc();
        feed_word(32'h0020_81b3, 4'd2);
        // stray valid words during the reset pulse must not be accepted
        data_valid = 1'b1;
        dataIN     = 32'hdead_beef;
        for (int k = 0; k < 2; k++) begin
            #1;
            vecs++;
            if ({core_rst, core_en, data_ready, imem_we} !== 4'b1000) begin
                errs++;
                $display("FAIL crst%0d: got rst/en/rdy/we %b%b%b%b want 1000",
                         k, core_rst, core_en, data_ready, imem_we);
            end
            cyc();
        end
        data_valid = 1'b0;
        #1;
        vecs++;
        if ({core_rst, core_en, run_cycles} !== {2'b01, 32'd0}) begin
            errs++;
            $display("FAIL run_entry: got rst/en %b%b run %0d want 01 run 0",
                     core_rst, core_en, run_cycles);
        end
        vecs++;
        if (nwr - w0 !== 3) begin
            errs++;
            $display("FAIL write_count: got %0d want 3", nwr - w0);
        end
    endtask

    task automatic test_halt5();
        for (int k = 1; k <= 5; k++) begin
            vecs++;
            if ({core_en, run_cycles} !== {1'b1, 32'(k - 1)}) begin
                errs++;
                $display("FAIL run%0d: got en %b run %0d want 1 run %0d",
                         k, core_en, run_cycles, k - 1);
            end
            if (k == 5) halt_req = 1'b1;
            cyc();
        end
        halt_req = 1'b0;
        #1;
        vecs++;
        if ({done, timeout, core_en, core_rst, run_cycles} !== {4'b1000, 32'd5}) begin
            errs++;
            $display("FAIL halt5: got done/to/en/rst %b%b%b%b run %0d want 1000 run 5",
                     done, timeout, core_en, core_rst, run_cycles);
        end
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        #1;
        vecs++;
        if ({done, run_cycles} !== {1'b1, 32'd5}) begin
            errs++;
            $display("FAIL halt_hold: got done %b run %0d want 1 run 5", done, run_cycles);
        end
    endtask

    task automatic test_timeout();
        reload_one(32'd5);
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (k == 1 || k == 20) begin
                vecs++;
                if ({core_en, run_cycles} !== {1'b1, 32'(k - 1)}) begin
                    errs++;
                    $display("FAIL wd_run%0d: got en %b run %0d want 1 run %0d",
                             k, core_en, run_cycles, k - 1);
                end
            end
            cyc();
        end
        #1;
        vecs++;
        if ({done, timeout, core_en, run_cycles} !== {3'b110, 32'd20}) begin
            errs++;
            $display("FAIL watchdog: got done/to/en %b%b%b run %0d want 110 run 20",
                     done, timeout, core_en, run_cycles);
        end
    endtask

    task automatic test_halt_at_limit();
        reload_one(32'd20);
        for (int k = 1; k <= 20; k++) begin
            if (k == 20) halt_req = 1'b1;
            cyc();
        end
        halt_req = 1'b0;
        #1;
        vecs++;
        if ({done, timeout, core_en, run_cycles} !== {3'b100, 32'd20}) begin
            errs++;
            $display("FAIL halt_wins: got done/to/en %b%b%b run %0d want 100 run 20",
                     done, timeout, core_en, run_cycles);
        end
    endtask

    task automatic test_reset_midload();
        int w0;
        w0 = nwr;
        start_load = 1'b1;
        load_len   = 4'd3;
        cyc();
        start_load = 1'b0;
        feed_word(32'h1111_1111, 4'd0);
        feed_word(32'h2222_2222, 4'd1);
        // reset beats a simultaneous start_load
        rst        = 1'b1;
        start_load = 1'b1;
        load_len   = 4'd5;
        cyc();
        rst        = 1'b0;
        load_len   = 4'd0;
        #1;
        vecs++;
        if ({core_rst, core_en, data_ready, imem_we, done, imem_addr, run_cycles} !==
            {5'b10000, 4'd0, 32'd0}) begin
            errs++;
            $display("FAIL rst_midload: got %b%b%b%b%b addr %0d run %0d want 10000 0 0",
                     core_rst, core_en, data_ready, imem_we, done, imem_addr, run_cycles);
        end
        cyc();
        start_load = 1'b0;
        #1;
        vecs++;
        if ({core_rst, core_en, data_ready} !== 3'b100) begin
            errs++;
            $display("FAIL len0_ignored: got rst/en/rdy %b%b%b want 100",
                     core_rst, core_en, data_ready);
        end
        start_load = 1'b1;
        load_len   = 4'd2;
        cyc();
        start_load = 1'b0;
        feed_word(32'haaaa_aaaa, 4'd0);
        feed_word(32'hbbbb_bbbb, 4'd1);
        #1;
        vecs++;
        if ({core_rst, data_ready, nwr - w0} !== {2'b10, 32'd4}) begin
            errs++;
            $display("FAIL reload2: got rst/rdy %b%b writes %0d want 10 writes 4",
                     core_rst, data_ready, nwr - w0);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_halt5();
        test_timeout();
        test_halt_at_limit();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
